// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Definitions shared by the pipeline control logic: the controller state
// encoding, the canonical NOP instruction word, and the default drain and
// watchdog limits.
// ---------------------------------------------------------------------------
package pipe_pkg;

  // Controller state encoding (two bits, legacy-compatible constants)
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;
  localparam logic [1:0] ST_HALTED   = 2'd3;

  // addi x0, x0, 0 -- injected into Dec on flush and into Exec on bubble
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Cycles needed to drain Dec..WB once the halt instruction is seen in IF
  localparam int DRAIN_CYCLES_DEF = 4;

  // Consecutive data-memory wait cycles tolerated before flagging an error
  localparam int WDOG_LIMIT_DEF = 255;

  // Width of the drain / watchdog / stall counters
  localparam int CNT_W = 16;

endpackage : pipe_pkg

// File: rtl/stall_flush_ctrl.sv
// ---------------------------------------------------------------------------
// stall_flush_ctrl
// Central stall / flush / halt controller for the 5-stage pipeline. Detects
// load-use hazards, squashes the wrong-path instruction after a redirect,
// freezes the whole pipe while the data memory is busy (with a watchdog),
// and drains the pipe after the halt instruction is fetched.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   dec_rs1/rs2, dec_use_*    sources read by the instruction in Dec
//   ex_rd, ex_is_load, ex_wen destination / kind of the instruction in Exec
//   redirect                  Dec resolved a taken branch or jump
//   halt_if                   IF fetched the halt instruction
//   mem_req, mem_ready        Mem-stage data access request / completion
//   stall_if/dec/ex/all       hold the named pipeline register(s)
//   flush_dec                 load NOP into Instruction_Dec on the next edge
//   bubble_ex                 load NOP, clear wrEn/mem_wEn in Exec next edge
//   halt_out                  core halted (left only through reset)
//   wdog_err                  sticky data-memory timeout
//   stall_cnt                 saturating count of cycles with any stall
// ---------------------------------------------------------------------------
module stall_flush_ctrl
  import pipe_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int WDOG_LIMIT   = WDOG_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_use_rs1,
  input  logic        dec_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_wen,
  input  logic        redirect,
  input  logic        halt_if,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_dec,
  output logic        stall_ex,
  output logic        stall_all,
  output logic        flush_dec,
  output logic        bubble_ex,
  output logic        halt_out,
  output logic        wdog_err,
  output logic [15:0] stall_cnt
);

  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] WDOG_MAX   = CNT_W'(WDOG_LIMIT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             ret_drain_q, ret_drain_d;
  logic             halt_out_q, halt_out_d;
  logic             wdog_err_q, wdog_err_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mem_stall;
  logic hz_en;       // pipeline advances this cycle: hazard responses apply
  logic drain_tick;  // one drain cycle consumed this cycle
  logic s_if, s_dec, s_all, s_flush, s_bubble;
  logic any_stall;

  assign load_use = ex_is_load & ex_wen & (ex_rd != 5'd0) &
                    ((dec_use_rs1 & (dec_rs1 == ex_rd)) |
                     (dec_use_rs2 & (dec_rs2 == ex_rd)));

  assign mem_stall = mem_req & ~mem_ready;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    wdog_cnt_d  = wdog_cnt_q;
    ret_drain_d = ret_drain_q;
    wdog_err_d  = wdog_err_q;
    s_if        = 1'b0;
    s_dec       = 1'b0;
    s_all       = 1'b0;
    s_flush     = 1'b0;
    s_bubble    = 1'b0;
    hz_en       = 1'b0;
    drain_tick  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          s_all       = 1'b1;
          state_d     = ST_MEM_WAIT;
          wdog_cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
          ret_drain_d = 1'b0;
        end else begin
          hz_en = 1'b1;
          // A halt seen on the same cycle as a redirect is on the wrong path;
          // a halt under load_use is simply re-presented next cycle.
          if (halt_if && !load_use && !redirect) begin
            s_if        = 1'b1;
            state_d     = (DRAIN_INIT == '0) ? ST_HALTED : ST_DRAIN;
            drain_cnt_d = DRAIN_INIT;
          end
        end
      end

      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          s_all = 1'b1;
          if (wdog_cnt_q != {CNT_W{1'b1}}) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
          end
        end else begin
          // Memory completes: the pipe advances this cycle in the mode we
          // left, so hazards apply and a pending drain keeps counting.
          hz_en      = 1'b1;
          s_if       = ret_drain_q;
          drain_tick = ret_drain_q;
          state_d    = ret_drain_q ? ST_DRAIN : ST_RUN;
        end
      end

      ST_DRAIN: begin
        s_if = 1'b1;
        if (mem_stall) begin
          s_all       = 1'b1;
          state_d     = ST_MEM_WAIT;
          wdog_cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
          ret_drain_d = 1'b1;
        end else begin
          hz_en      = 1'b1;
          drain_tick = 1'b1;
        end
      end

      default: begin  // ST_HALTED
        s_all = 1'b1;
      end
    endcase

    if (hz_en) begin
      if (load_use) begin
        s_if     = 1'b1;
        s_dec    = 1'b1;
        s_bubble = 1'b1;
      end else if (redirect) begin
        s_flush = 1'b1;
      end
    end

    if (drain_tick) begin
      if (drain_cnt_q != '0) begin
        drain_cnt_d = drain_cnt_q - 1'b1;
      end
      if (drain_cnt_d == '0) begin
        state_d = ST_HALTED;
      end
    end

    if (state_d == ST_MEM_WAIT && wdog_cnt_d >= WDOG_MAX) begin
      wdog_err_d = 1'b1;
    end

    halt_out_d = (state_d == ST_HALTED);
  end

  // Outputs are forced low while reset is held, even though the hazard
  // terms are combinational from the inputs.
  assign stall_if  = s_if & rstn;
  assign stall_dec = s_dec & rstn;
  assign stall_all = s_all & rstn;
  assign stall_ex  = s_all & rstn;
  assign flush_dec = s_flush & rstn;
  assign bubble_ex = s_bubble & rstn;

  assign any_stall = stall_if | stall_dec | stall_ex | stall_all;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (any_stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      wdog_cnt_q  <= '0;
      ret_drain_q <= 1'b0;
      halt_out_q  <= 1'b0;
      wdog_err_q  <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wdog_cnt_q  <= wdog_cnt_d;
      ret_drain_q <= ret_drain_d;
      halt_out_q  <= halt_out_d;
      wdog_err_q  <= wdog_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halt_out  = halt_out_q;
  assign wdog_err  = wdog_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule : stall_flush_ctrl

// File: tb/tb_stall_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stall_flush_ctrl
// Directed bench for stall_flush_ctrl: a vector table for the single-cycle
// hazard decisions in RUN, plus hand-written multi-cycle sequences for
// memory wait, watchdog, halt/drain timing and reset behaviour.
// ---------------------------------------------------------------------------
module tb_stall_flush_ctrl;

  logic        clk;
  logic        rstn;
  logic [4:0]  dec_rs1, dec_rs2, ex_rd;
  logic        dec_use_rs1, dec_use_rs2, ex_is_load, ex_wen;
  logic        redirect, halt_if, mem_req, mem_ready;
  logic        stall_if, stall_dec, stall_ex, stall_all;
  logic        flush_dec, bubble_ex, halt_out, wdog_err;
  logic [15:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  stall_flush_ctrl #(.DRAIN_CYCLES(4), .WDOG_LIMIT(255)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .dec_rs1    (dec_rs1),
    .dec_rs2    (dec_rs2),
    .dec_use_rs1(dec_use_rs1),
    .dec_use_rs2(dec_use_rs2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .ex_wen     (ex_wen),
    .redirect   (redirect),
    .halt_if    (halt_if),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .stall_if   (stall_if),
    .stall_dec  (stall_dec),
    .stall_ex   (stall_ex),
    .stall_all  (stall_all),
    .flush_dec  (flush_dec),
    .bubble_ex  (bubble_ex),
    .halt_out   (halt_out),
    .wdog_err   (wdog_err),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       ld, wen, rdr, mreq, mrdy;
    logic       e_if, e_dec, e_ex, e_all, e_fl, e_bub;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_wen = 1'b0;
    redirect = 1'b0; halt_if = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Fetches halt, optionally inserts a two-cycle memory wait starting on
  // edge wait_start, and reports on which edge halt_out first reads 1.
  task automatic run_halt(input int wait_start, output int edges);
    edges = 0;
    for (int e = 1; e <= 20; e++) begin
      halt_if   = (e == 1);
      mem_req   = 1'b0;
      mem_ready = 1'b0;
      if (wait_start != 0 && (e == wait_start || e == wait_start + 1)) begin
        mem_req = 1'b1;
      end
      if (wait_start != 0 && e == wait_start + 2) begin
        mem_req   = 1'b1;
        mem_ready = 1'b1;
      end
      next_edge();
      if (halt_out && edges == 0) edges = e;
    end
    idle_inputs();
  endtask

  int exp_cnt;
  int edges;

  initial begin
    rstn = 1'b0;
    idle_inputs();

    // rs1,rs2,u1,u2,rd, ld,wen,rdr,mreq,mrdy, if,dec,ex,all,fl,bub
    vecs[0]  = '{5'd0,  5'd0, 0,0, 5'd0,  0,0,0,0,0, 0,0,0,0,0,0};
    vecs[1]  = '{5'd5,  5'd1, 1,1, 5'd5,  1,1,0,0,0, 1,1,0,0,0,1};
    vecs[2]  = '{5'd1,  5'd5, 1,1, 5'd5,  1,1,0,0,0, 1,1,0,0,0,1};
    vecs[3]  = '{5'd5,  5'd0, 0,1, 5'd5,  1,1,0,0,0, 0,0,0,0,0,0};
    vecs[4]  = '{5'd0,  5'd0, 1,1, 5'd0,  1,1,0,0,0, 0,0,0,0,0,0};
    vecs[5]  = '{5'd5,  5'd0, 1,0, 5'd5,  0,1,0,0,0, 0,0,0,0,0,0};
    vecs[6]  = '{5'd5,  5'd0, 1,0, 5'd5,  1,0,0,0,0, 0,0,0,0,0,0};
    vecs[7]  = '{5'd0,  5'd0, 0,0, 5'd0,  0,0,1,0,0, 0,0,0,0,1,0};
    vecs[8]  = '{5'd5,  5'd1, 1,1, 5'd5,  1,1,1,0,0, 1,1,0,0,0,1};
    vecs[9]  = '{5'd3,  5'd4, 1,1, 5'd5,  1,1,1,0,0, 0,0,0,0,1,0};
    vecs[10] = '{5'd0,  5'd0, 0,0, 5'd0,  0,0,0,1,1, 0,0,0,0,0,0};
    vecs[11] = '{5'd31, 5'd2, 1,1, 5'd31, 1,1,0,0,0, 1,1,0,0,0,1};
    vecs[12] = '{5'd7,  5'd5, 0,1, 5'd5,  1,1,0,0,0, 1,1,0,0,0,1};

    // ---- outputs held low during reset, even with a live hazard ----
    repeat (2) @(posedge clk);
    #1;
    dec_rs1 = 5'd5; dec_use_rs1 = 1'b1; ex_rd = 5'd5; ex_is_load = 1'b1;
    ex_wen = 1'b1; redirect = 1'b1; mem_req = 1'b1;
    #2;
    chk("rst.stall_if",  stall_if,  0);
    chk("rst.stall_all", stall_all, 0);
    chk("rst.bubble_ex", bubble_ex, 0);
    chk("rst.halt_out",  halt_out,  0);
    chk("rst.wdog_err",  wdog_err,  0);
    chk("rst.stall_cnt", stall_cnt, 0);

    // ---- single-cycle hazard decisions from RUN ----
    do_reset();
    exp_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      dec_rs1 = vecs[i].rs1; dec_rs2 = vecs[i].rs2;
      dec_use_rs1 = vecs[i].u1; dec_use_rs2 = vecs[i].u2;
      ex_rd = vecs[i].rd; ex_is_load = vecs[i].ld; ex_wen = vecs[i].wen;
      redirect = vecs[i].rdr; mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
      halt_if = 1'b0;
      #2;
      chk($sformatf("vec%0d.stall_if", i),  stall_if,  vecs[i].e_if);
      chk($sformatf("vec%0d.stall_dec", i), stall_dec, vecs[i].e_dec);
      chk($sformatf("vec%0d.stall_ex", i),  stall_ex,  vecs[i].e_ex);
      chk($sformatf("vec%0d.stall_all", i), stall_all, vecs[i].e_all);
      chk($sformatf("vec%0d.flush_dec", i), flush_dec, vecs[i].e_fl);
      chk($sformatf("vec%0d.bubble_ex", i), bubble_ex, vecs[i].e_bub);
      if (vecs[i].e_if | vecs[i].e_dec | vecs[i].e_ex | vecs[i].e_all) exp_cnt++;
      @(posedge clk);
      #1;
    end
    idle_inputs();
    chk("table.stall_cnt", stall_cnt, exp_cnt);

    // ---- load-use then forwarding: one cycle of stall only ----
    dec_rs1 = 5'd5; dec_rs2 = 5'd1; dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1;
    ex_rd = 5'd5; ex_is_load = 1'b1; ex_wen = 1'b1; redirect = 1'b1;
    #2;
    chk("lu_rdr.bubble_ex", bubble_ex, 1);
    chk("lu_rdr.flush_dec", flush_dec, 0);
    next_edge();
    ex_is_load = 1'b0; ex_wen = 1'b0; ex_rd = 5'd0;  // bubble now in Exec
    #2;
    chk("lu_next.stall_if",  stall_if,  0);
    chk("lu_next.bubble_ex", bubble_ex, 0);
    chk("lu_next.flush_dec", flush_dec, 1);
    next_edge();
    idle_inputs();

    // ---- memory wait of three cycles ----
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("mw%0d.stall_all", c), stall_all, 1);
      chk($sformatf("mw%0d.stall_ex", c),  stall_ex,  1);
      next_edge();
    end
    mem_ready = 1'b1;
    #2;
    chk("mw_done.stall_all", stall_all, 0);
    next_edge();
    mem_req = 1'b0; mem_ready = 1'b0;
    #2;
    chk("mw_run.stall_all", stall_all, 0);
    chk("mw_run.wdog_err",  wdog_err,  0);
    chk("mw_run.stall_cnt", stall_cnt, 3);
    next_edge();

    // ---- watchdog after 255 wait cycles, sticky afterwards ----
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int k = 0; k < 254; k++) next_edge();
    chk("wd254.wdog_err", wdog_err, 0);
    next_edge();
    chk("wd255.wdog_err",  wdog_err,  1);
    chk("wd255.stall_all", stall_all, 1);
    mem_ready = 1'b1;
    #2;
    chk("wd_ready.stall_all", stall_all, 0);
    next_edge();
    mem_req = 1'b0; mem_ready = 1'b0;
    next_edge();
    chk("wd_sticky.wdog_err",  wdog_err,  1);
    chk("wd_sticky.stall_all", stall_all, 0);

    // ---- halt drains in DRAIN_CYCLES+1 edges ----
    do_reset();
    run_halt(0, edges);
    chk("halt.edges", edges, 5);
    chk("halted.stall_all", stall_all, 1);
    redirect = 1'b1;
    #2;
    chk("halted.flush_dec", flush_dec, 0);
    idle_inputs();
    repeat (3) next_edge();
    chk("halted.halt_out", halt_out, 1);

    // ---- halt with two memory wait cycles during drain ----
    do_reset();
    run_halt(2, edges);
    chk("halt_wait.edges", edges, 7);

    // ---- halt on the wrong path is ignored ----
    do_reset();
    halt_if = 1'b1; redirect = 1'b1;
    #2;
    chk("halt_rdr.flush_dec", flush_dec, 1);
    next_edge();
    idle_inputs();
    #2;
    chk("halt_rdr.stall_if", stall_if, 0);
    repeat (8) next_edge();
    chk("halt_rdr.halt_out", halt_out, 0);

    // ---- reset pulsed while draining ----
    do_reset();
    halt_if = 1'b1;
    next_edge();
    halt_if = 1'b0;
    next_edge();
    #2;
    chk("drain.stall_if", stall_if, 1);
    rstn = 1'b0;
    #1;
    chk("drain_rst.stall_cnt", stall_cnt, 0);
    chk("drain_rst.halt_out",  halt_out,  0);
    chk("drain_rst.stall_if",  stall_if,  0);
    @(posedge clk);
    #1 rstn = 1'b1;
    #2;
    chk("after_rst.stall_if", stall_if, 0);
    repeat (8) next_edge();
    chk("after_rst.halt_out",  halt_out,  0);
    chk("after_rst.stall_cnt", stall_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_stall_flush_ctrl

// File: doc/stall_flush_ctrl.md
STALL_FLUSH_CTRL -- requirements
Module: stall_flush_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, 4, cycles to drain Dec..WB after halt detected in IF.
REQ-002 Parameter WDOG_LIMIT, 255, max consecutive data-memory wait cycles before error.
REQ-003 One clock; reset is asynchronous and active-low; ports named clk and rstn.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rstn  in  1  async active-low reset.
REQ-006 dec_rs1, dec_rs2  in  5 each  source registers of instruction in Dec.
REQ-007 dec_use_rs1, dec_use_rs2  in  1 each  Dec instruction reads that source.
REQ-008 ex_rd  in  5  destination of instruction in Exec.
REQ-009 ex_is_load, ex_wen  in  1 each  Exec holds a load; Exec writes a register.
REQ-010 redirect  in  1  Dec resolved a taken branch/jump (npc_control).
REQ-011 halt_if  in  1  IF fetched the halt instruction.
REQ-012 mem_req, mem_ready  in  1 each  Mem-stage data access request; memory done.
REQ-013 stall_if, stall_dec, stall_ex, stall_all  out  1 each  hold the named pipeline register(s).
REQ-014 flush_dec  out  1  load NOP 0x00000013 into Instruction_Dec next edge.
REQ-015 bubble_ex  out  1  load NOP and clear wrEn/mem_wEn in Exec next edge.
REQ-016 halt_out  out  1  core halted; wdog_err  out  1  sticky memory-timeout error.
REQ-017 stall_cnt  out  16  saturating count of cycles with any stall asserted.

Function
REQ-018 State machine RUN, MEM_WAIT, DRAIN, HALTED; stall/flush outputs combinational from state and inputs; state, counters, halt_out, wdog_err, stall_cnt registered.
REQ-019 load_use = ex_is_load & ex_wen & ex_rd!=0 & ((dec_use_rs1 & dec_rs1==ex_rd) | (dec_use_rs2 & dec_rs2==ex_rd)).
REQ-020 Priority per cycle: stall_all > load_use > redirect > halt_if.
REQ-021 RUN, mem_req & !mem_ready: stall_all=1 same cycle; next state MEM_WAIT; watchdog counter loads 1.
REQ-022 MEM_WAIT: stall_all=1 while !mem_ready, counter increments; mem_ready: stall_all=0 that cycle, return to RUN (or DRAIN if entered from DRAIN).
REQ-023 Counter reaching WDOG_LIMIT sets wdog_err (sticky until reset); state stays MEM_WAIT.
REQ-024 load_use (no stall_all): stall_if=1, stall_dec=1, bubble_ex=1 for exactly one cycle; next cycle forwarding covers the dependency.
REQ-025 redirect (no stall_all, no load_use): flush_dec=1 one cycle; redirect ignored when load_use is true (operands invalid).
REQ-026 halt_if in RUN, no redirect same cycle: stall_if=1 thereafter; state DRAIN; drain counter = DRAIN_CYCLES.
REQ-027 halt_if coincident with redirect: halt_if ignored (wrong path), no state change.
REQ-028 DRAIN: counter decrements on cycles without stall_all; load_use/redirect still honoured; at 0 go HALTED.
REQ-029 HALTED: halt_out=1, stall_all=1; exits only by reset.
REQ-030 stall_cnt increments when any of stall_if/stall_dec/stall_ex/stall_all is 1; saturates at 0xFFFF.
REQ-031 stall_ex=1 only when stall_all=1.

Reset
REQ-032 rstn low: state RUN, counters 0, halt_out=0, wdog_err=0, stall_cnt=0; all outputs 0 while asserted.
REQ-033 Reset mid-MEM_WAIT or DRAIN abandons operation; first cycle after release is RUN.

Structure
REQ-034 State encoding, NOP constant 0x00000013 and DRAIN_CYCLES/WDOG_LIMIT defaults in shared package pipe_pkg.
REQ-035 Single module; no sub-modules; pipeline_top replaces its hazard instance and tie-offs with this block.

Verification
REQ-036 lw x5 in Exec, Dec add x6,x5,x1 -> one cycle stall_if=stall_dec=bubble_ex=1, then 0; x6 correct.
REQ-037 ex_rd=0 load, dec_rs1=0 -> no stall.
REQ-038 redirect=1 with load_use=1 -> only load-use response; next cycle redirect=1 -> flush_dec=1.
REQ-039 mem_req=1, mem_ready low 3 cycles -> stall_all=1 for 3 cycles, RUN on 4th; low 255 cycles -> wdog_err=1.
REQ-040 halt_if=1 -> halt_out=1 after DRAIN_CYCLES+1 edges; with 2 wait cycles during drain, +2; halt_if+redirect -> no halt.
REQ-041 rstn pulsed in DRAIN -> halt_out=0, stall_cnt=0, state RUN.
